mux_nto1_reg: RTL



---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_scan_ctr.sv | 56 +++++
 rtl/mux_nto1_reg.sv | 85 ++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 registered selector: mode encoding and
// the helper that sizes select / channel-tag fields.
package mux_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mux_mode_t;

    // Width of a field able to hold any channel index 0..nch-1 (never below 1).
    function automatic int sel_width(input int nch);
        return (nch < 2) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Round-robin channel counter for scan mode. Holds scan_ch, dwell_cnt and
// prev_mode. Entering scan mode restarts at channel 0 in the same cycle, so a
// capture on that cycle already sees channel 0 on scan_ch.
module mux_scan_ctr
    import mux_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DWELL = 1,
    localparam int SELW = sel_width(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    input  logic            mode,
    output logic [SELW-1:0] scan_ch
);

    localparam int CW = $clog2(DWELL + 1);

    mux_mode_t       prev_mode;
    logic [SELW-1:0] ch_q;
    logic [CW-1:0]   dwell_cnt;
    logic            restart;
    logic [SELW-1:0] ch_cur;
    logic [CW-1:0]   cnt_cur;

    // A DIRECT->SCAN edge overrides the stored counters for this cycle.
    assign restart = (mode == MODE_SCAN) && (prev_mode == MODE_DIRECT);
    assign ch_cur  = restart ? '0 : ch_q;
    assign cnt_cur = restart ? '0 : dwell_cnt;
    assign scan_ch = ch_cur;

    // Counter state: dwell per channel, wrap at NCH-1 so unused codes are skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_mode <= MODE_DIRECT;
            ch_q      <= '0;
            dwell_cnt <= '0;
        end else begin
            prev_mode <= mux_mode_t'(mode);
            if (advance) begin
                if (cnt_cur == CW'(DWELL - 1)) begin
                    dwell_cnt <= '0;
                    ch_q      <= (ch_cur == SELW'(NCH - 1)) ? '0 : ch_cur + 1'b1;
                end else begin
                    dwell_cnt <= cnt_cur + 1'b1;
                    ch_q      <= ch_cur;
                end
            end else if (restart) begin
                ch_q      <= '0;
                dwell_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_reg.sv
// N-channel, W-bit registered selector with active-low enable, direct or
// round-robin scan channel choice and a valid/ready output handshake.
// Optional macro MUX_PARITY_EN adds y_par, the XOR of the captured slice.
module mux_nto1_reg
    import mux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int NCH   = 4,
    parameter int DWELL = 1,
    localparam int SELW = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] d_in,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     y_out,
    output logic                 y_valid,
    output logic [SELW-1:0]      y_ch
`ifdef MUX_PARITY_EN
    ,
    output logic                 y_par
`endif
);

    logic            slot_free;
    logic            capture;
    logic [SELW-1:0] scan_ch;
    logic [SELW-1:0] ch;
    logic [WIDTH-1:0] slice;

    // The output register may load when empty or being drained this cycle.
    assign slot_free = !y_valid || out_ready;
    assign capture   = slot_free && !en_n;
    assign ch        = (mode == MODE_SCAN) ? scan_ch : sel;

    mux_scan_ctr #(
        .NCH   (NCH),
        .DWELL (DWELL)
    ) u_scan_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (capture && (mode == MODE_SCAN)),
        .mode    (mode),
        .scan_ch (scan_ch)
    );

    // Channel slice; codes at or above NCH match nothing and read as zero.
    always_comb begin
        slice = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch == SELW'(k)) slice = d_in[k*WIDTH +: WIDTH];
        end
    end

    // Output register: load on capture, clear on disabled slot, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_out   <= '0;
            y_valid <= 1'b0;
            y_ch    <= '0;
`ifdef MUX_PARITY_EN
            y_par   <= 1'b0;
`endif
        end else if (slot_free) begin
            if (en_n) begin
                y_out   <= '0;
                y_valid <= 1'b0;
`ifdef MUX_PARITY_EN
                y_par   <= 1'b0;
`endif
            end else begin
                y_out   <= slice;
                y_valid <= 1'b1;
                y_ch    <= ch;
`ifdef MUX_PARITY_EN
                y_par   <= ^slice;
`endif
            end
        end
    end

endmodule
